// File: rtl/state_registers_par.sv
// 16-byte column-major state register with byte-serial load/unload and
// in-place ShiftRows / MixColumns (optionally their inverses).
module state_registers_par #(
    parameter int LANES  = 1,
    parameter int INV_EN = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 op_valid,
    output logic                 op_ready,
    input  logic [1:0]           op,
    input  logic                 inv,
    input  logic [8*LANES-1:0]   din,
    input  logic                 din_valid,
    output logic                 din_ready,
    output logic [8*LANES-1:0]   dout,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic                 done
);

    localparam int BEATS = 16 / LANES;
    localparam int CW    = (BEATS > 2) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST    = CW'(BEATS - 1);
    localparam logic [CW-1:0] MC_LAST = CW'(3);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_SR     = 3'd2;
    localparam logic [2:0] ST_MC     = 3'd3;
    localparam logic [2:0] ST_UNLOAD = 3'd4;

    generate
        if (LANES != 1 && LANES != 2 && LANES != 4) begin : g_bad_lanes
            $error("state_registers_par: LANES must be 1, 2 or 4");
        end
    endgenerate

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic          inv_q;
    logic          use_inv;
    logic [7:0]    s     [16];
    logic [7:0]    s_nxt [16];
    logic [31:0]   mixed;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a 4-bit constant: enough for 01/02/03/09/0B/0D/0E.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] c);
        logic [7:0] a2, a4, a8;
        a2 = xt(a);
        a4 = xt(a2);
        a8 = xt(a4);
        return (c[0] ? a : 8'h00) ^ (c[1] ? a2 : 8'h00) ^
               (c[2] ? a4 : 8'h00) ^ (c[3] ? a8 : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] col, input logic iv);
        logic [3:0]  k0, k1, k2, k3;
        logic [31:0] res;
        k0 = iv ? 4'he : 4'h2;
        k1 = iv ? 4'hb : 4'h3;
        k2 = iv ? 4'hd : 4'h1;
        k3 = iv ? 4'h9 : 4'h1;
        res = '0;
        for (int j = 0; j < 4; j++) begin
            res[8*j +: 8] = gmul(col[8*j +: 8], k0) ^
                            gmul(col[8*((j+1)%4) +: 8], k1) ^
                            gmul(col[8*((j+2)%4) +: 8], k2) ^
                            gmul(col[8*((j+3)%4) +: 8], k3);
        end
        return res;
    endfunction

    assign use_inv    = (INV_EN != 0) && inv_q;
    assign op_ready   = (state == ST_IDLE);
    assign din_ready  = (state == ST_LOAD);
    assign dout_valid = (state == ST_UNLOAD);

    always_comb begin
        mixed = mix_col({s[3], s[2], s[1], s[0]}, use_inv);
    end

    genvar gk;
    generate
        for (gk = 0; gk < LANES; gk++) begin : g_dout
            assign dout[8*gk +: 8] = dout_valid ? s[gk] : 8'h00;
        end
    endgenerate

    always_comb begin
        for (int i = 0; i < 16; i++) s_nxt[i] = s[i];
        case (state)
            ST_LOAD: if (din_valid) begin
                for (int i = 0; i < 16 - LANES; i++) s_nxt[i] = s[i+LANES];
                for (int k = 0; k < LANES; k++) s_nxt[16-LANES+k] = din[8*k +: 8];
            end
            ST_SR: begin
                for (int r = 0; r < 4; r++) begin
                    for (int c = 0; c < 4; c++) begin
                        if (use_inv) s_nxt[r+4*c] = s[r+4*((c-r+4)%4)];
                        else         s_nxt[r+4*c] = s[r+4*((c+r)%4)];
                    end
                end
            end
            // Rotate by one column; after four passes every column is back home, mixed.
            ST_MC: begin
                for (int i = 0; i < 12; i++) s_nxt[i] = s[i+4];
                for (int j = 0; j < 4; j++) s_nxt[12+j] = mixed[8*j +: 8];
            end
            ST_UNLOAD: if (dout_ready) begin
                for (int i = 0; i < 16; i++) s_nxt[i] = s[(i+LANES)%16];
            end
            default: ;
        endcase
    end

    always_comb begin
        done = 1'b0;
        if (!rst) begin
            case (state)
                ST_LOAD:   done = din_valid && (cnt == LAST);
                ST_SR:     done = 1'b1;
                ST_MC:     done = (cnt == MC_LAST);
                ST_UNLOAD: done = dout_ready && (cnt == LAST);
                default:   done = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            inv_q <= 1'b0;
            for (int i = 0; i < 16; i++) s[i] <= 8'h00;
        end else begin
            for (int i = 0; i < 16; i++) s[i] <= s_nxt[i];
            case (state)
                ST_IDLE: if (op_valid) begin
                    inv_q <= (INV_EN != 0) ? inv : 1'b0;
                    case (op)
                        2'b00:   state <= ST_LOAD;
                        2'b01:   state <= ST_SR;
                        2'b10:   state <= ST_MC;
                        default: state <= ST_UNLOAD;
                    endcase
                end
                ST_LOAD: if (din_valid) begin
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_SR: state <= ST_IDLE;
                ST_MC: begin
                    if (cnt == MC_LAST) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_UNLOAD: if (dout_ready) begin
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_state_registers_par.sv
// Directed bench: a LANES=1/INV_EN=1 instance for the transform vectors and
// reset corners, and a LANES=4/INV_EN=0 instance for wide beats and stalls.
module tb_state_registers_par;

    localparam logic [1:0] OP_LOAD = 2'b00, OP_SR = 2'b01, OP_MC = 2'b10, OP_UNLOAD = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       op_valid1 = 0, op_ready1, inv1 = 0, din_valid1 = 0, din_ready1;
    logic       dout_valid1, dout_ready1 = 0, done1;
    logic [1:0] op1 = 0;
    logic [7:0] din1 = 0, dout1;

    logic        op_valid4 = 0, op_ready4, inv4 = 0, din_valid4 = 0, din_ready4;
    logic        dout_valid4, dout_ready4 = 0, done4;
    logic [1:0]  op4 = 0;
    logic [31:0] din4 = 0, dout4;

    state_registers_par #(.LANES(1), .INV_EN(1)) dut1 (
        .clk(clk), .rst(rst), .op_valid(op_valid1), .op_ready(op_ready1), .op(op1),
        .inv(inv1), .din(din1), .din_valid(din_valid1), .din_ready(din_ready1),
        .dout(dout1), .dout_valid(dout_valid1), .dout_ready(dout_ready1), .done(done1));

    state_registers_par #(.LANES(4), .INV_EN(0)) dut4 (
        .clk(clk), .rst(rst), .op_valid(op_valid4), .op_ready(op_ready4), .op(op4),
        .inv(inv4), .din(din4), .din_valid(din_valid4), .din_ready(din_ready4),
        .dout(dout4), .dout_valid(dout_valid4), .dout_ready(dout_ready4), .done(done4));

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [1:0]   op_a;
        logic         inv_a;
        logic         two;
        logic [1:0]   op_b;
        logic         inv_b;
        logic [127:0] data;
        logic [127:0] exp;
    } vec_t;
    vec_t vt [8];

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic cmd1(input logic [1:0] o, input logic iv);
        op1 = o; inv1 = iv; op_valid1 = 1;
        @(posedge clk); #1;
        op_valid1 = 0;
    endtask

    task automatic cmd4(input logic [1:0] o, input logic iv);
        op4 = o; inv4 = iv; op_valid4 = 1;
        @(posedge clk); #1;
        op_valid4 = 0;
    endtask

    task automatic load1(input logic [127:0] d, input string nm);
        int dn, at;
        dn = 0; at = -1;
        cmd1(OP_LOAD, 1'b0);
        for (int i = 0; i < 16; i++) begin
            din1 = d[127-8*i -: 8]; din_valid1 = 1;
            @(negedge clk);
            if (done1) begin dn++; at = i; end
            @(posedge clk); #1;
        end
        din_valid1 = 0;
        chk({nm, "_load_done"}, {dn[7:0], at[7:0]}, {8'd1, 8'd15});
    endtask

    task automatic unload1(output logic [127:0] got, input string nm);
        int dn, at;
        dn = 0; at = -1; got = '0;
        cmd1(OP_UNLOAD, 1'b0);
        dout_ready1 = 1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            got[127-8*i -: 8] = dout1;
            if (done1) begin dn++; at = i; end
            @(posedge clk); #1;
        end
        dout_ready1 = 0;
        chk({nm, "_unload_done"}, {dn[7:0], at[7:0]}, {8'd1, 8'd15});
    endtask

    task automatic run_op1(input logic [1:0] o, input logic iv, input string nm);
        int lat;
        lat = -1;
        cmd1(o, iv);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done1) begin
                lat = k;
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
        chk({nm, "_latency"}, lat, (o == OP_MC) ? 3 : 0);
    endtask

    task automatic unload4(input bit stall, output logic [127:0] got, input string nm);
        int beats, dn, at, unstable, badv;
        logic [31:0] prev;
        bit have_prev;
        beats = 0; dn = 0; at = -1; unstable = 0; badv = 0; have_prev = 0; got = '0; prev = '0;
        cmd4(OP_UNLOAD, 1'b0);
        for (int cyc = 0; cyc < 200 && beats < 4; cyc++) begin
            dout_ready4 = !stall ? 1'b1 : (cyc == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            @(negedge clk);
            if (!dout_valid4) badv++;
            if (have_prev && dout4 !== prev) unstable++;
            if (done4) dn++;
            if (dout_ready4) begin
                for (int k = 0; k < 4; k++) got[127-8*(4*beats+k) -: 8] = dout4[8*k +: 8];
                if (done4) at = beats;
                beats++;
                have_prev = 0;
            end else begin
                prev = dout4;
                have_prev = 1;
            end
            @(posedge clk); #1;
        end
        dout_ready4 = 0;
        chk({nm, "_beats"}, beats, 4);
        chk({nm, "_stable_valid"}, {unstable[7:0], badv[7:0]}, 16'h0);
        chk({nm, "_done"}, {dn[7:0], at[7:0]}, {8'd1, 8'd3});
    endtask

    logic [127:0] got;
    int dn4, at4;

    initial begin
        vt[0] = '{OP_SR, 1'b0, 1'b0, OP_SR, 1'b0,
                  128'h000102030405060708090a0b0c0d0e0f, 128'h00050a0f04090e03080d02070c01060b};
        vt[1] = '{OP_SR, 1'b1, 1'b0, OP_SR, 1'b0,
                  128'h00050a0f04090e03080d02070c01060b, 128'h000102030405060708090a0b0c0d0e0f};
        vt[2] = '{OP_MC, 1'b0, 1'b0, OP_MC, 1'b0,
                  128'hdb135345db135345db135345db135345, 128'h8e4da1bc8e4da1bc8e4da1bc8e4da1bc};
        vt[3] = '{OP_MC, 1'b0, 1'b0, OP_MC, 1'b0,
                  128'hdb135345f20a225cd4d4d4d52d26314c, 128'h8e4da1bc9fdc589dd5d5d7d64d7ebdf8};
        vt[4] = '{OP_MC, 1'b1, 1'b0, OP_MC, 1'b0,
                  128'h8e4da1bc8e4da1bc8e4da1bc8e4da1bc, 128'hdb135345db135345db135345db135345};
        vt[5] = '{OP_MC, 1'b1, 1'b0, OP_MC, 1'b0,
                  128'h8e4da1bc9fdc589dd5d5d7d64d7ebdf8, 128'hdb135345f20a225cd4d4d4d52d26314c};
        vt[6] = '{OP_MC, 1'b0, 1'b1, OP_MC, 1'b1,
                  128'h000102030405060708090a0b0c0d0e0f, 128'h000102030405060708090a0b0c0d0e0f};
        vt[7] = '{OP_SR, 1'b0, 1'b1, OP_SR, 1'b1,
                  128'h112233445566778899aabbccddeeff00, 128'h112233445566778899aabbccddeeff00};

        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
        chk("reset_outs1", {op_ready1, din_ready1, dout_valid1, done1, dout1}, {4'b1000, 8'h00});
        chk("reset_outs4", {op_ready4, din_ready4, dout_valid4, done4, dout4}, {4'b1000, 32'h0});
        @(posedge clk); #1;

        for (int v = 0; v < 8; v++) begin
            load1(vt[v].data, $sformatf("vec%0d", v));
            run_op1(vt[v].op_a, vt[v].inv_a, $sformatf("vec%0d_a", v));
            if (vt[v].two) run_op1(vt[v].op_b, vt[v].inv_b, $sformatf("vec%0d_b", v));
            unload1(got, $sformatf("vec%0d", v));
            chk($sformatf("vec%0d_data", v), got, vt[v].exp);
        end
        @(negedge clk);
        chk("idle_outs1", {din_ready1, dout_valid1, dout1}, 10'h0);
        @(posedge clk); #1;

        // Reset during the second MC cycle aborts silently and clears the state.
        load1(128'h0102030405060708090a0b0c0d0e0f10, "abort");
        cmd1(OP_MC, 1'b0);
        @(posedge clk); #1;
        rst = 1;
        @(negedge clk);
        chk("abort_no_done", done1, 1'b0);
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("abort_idle", {op_ready1, done1, dout_valid1}, 3'b100);
        @(posedge clk); #1;
        unload1(got, "abort");
        chk("abort_cleared", got, 128'h0);

        // A command presented together with reset is dropped.
        rst = 1; op1 = OP_UNLOAD; op_valid1 = 1;
        @(posedge clk); #1;
        rst = 0; op_valid1 = 0;
        @(negedge clk);
        chk("cmd_with_rst", {op_ready1, din_ready1, dout_valid1}, 3'b100);
        @(posedge clk); #1;

        // op_valid held through SR is neither accepted nor queued.
        op1 = OP_SR; op_valid1 = 1;
        @(posedge clk); #1;
        op1 = OP_UNLOAD;
        @(negedge clk);
        chk("busy_not_ready", {op_ready1, done1}, 2'b01);
        @(posedge clk); #1;
        op_valid1 = 0;
        @(negedge clk);
        chk("op_ready_back", op_ready1, 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("no_queue", {op_ready1, dout_valid1}, 2'b10);
        @(posedge clk); #1;

        // Four-lane instance: gapped load, stalled unload, repeat unload, inv ignored.
        cmd4(OP_LOAD, 1'b0);
        dn4 = 0; at4 = -1;
        for (int b = 0; b < 4; b++) begin
            din_valid4 = 0;
            @(negedge clk);
            if (done4) dn4++;
            chk($sformatf("gap%0d_ready", b), din_ready4, 1'b1);
            @(posedge clk); #1;
            for (int k = 0; k < 4; k++) din4[8*k +: 8] = 8'h30 + 8'(4*b + k);
            din_valid4 = 1;
            @(negedge clk);
            if (done4) begin dn4++; at4 = b; end
            @(posedge clk); #1;
        end
        din_valid4 = 0;
        chk("load4_done", {dn4[7:0], at4[7:0]}, {8'd1, 8'd3});
        @(negedge clk);
        chk("load4_idle", {op_ready4, din_ready4}, 2'b10);
        @(posedge clk); #1;

        unload4(1'b1, got, "u4_stall");
        chk("u4_stall_data", got, 128'h303132333435363738393a3b3c3d3e3f);
        unload4(1'b0, got, "u4_again");
        chk("u4_again_data", got, 128'h303132333435363738393a3b3c3d3e3f);

        op4 = OP_SR; inv4 = 1; op_valid4 = 1;
        @(posedge clk); #1;
        op_valid4 = 0;
        @(negedge clk);
        chk("sr4_done", done4, 1'b1);
        @(posedge clk); #1;
        unload4(1'b0, got, "u4_sr");
        chk("u4_sr_data", got, 128'h30353a3f34393e33383d32373c31363b);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
